// File: rtl/openram_wb_port.sv
// Wishbone classic slave that turns management-core cycles into single-cycle
// port-0 commands on the shared OpenRAM SRAM bus, plus a small CSR block.
module openram_wb_port #(
  parameter int unsigned          ADDR_W    = 10,
  parameter int unsigned          MAX_CHIPS = 16,
  parameter int unsigned          RD_LAT    = 2,
  parameter logic [MAX_CHIPS-1:0] POP_MASK  = MAX_CHIPS'(16'h0F1F)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [ADDR_W-1:0]       addr0,
  output logic [31:0]             din0,
  output logic                    web0,
  output logic [3:0]              wmask0,
  output logic [MAX_CHIPS-1:0]    csb0,
  input  logic [32*MAX_CHIPS-1:0] sram_dout_i,
  output logic                    err_o
);

  localparam int unsigned CNT_W    = 3;
  localparam logic [31:0] ERR_WORD = 32'hBADC0DE0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           chip_q, chip_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MAX_CHIPS-1:0] pop_q, pop_d;
  logic                 err_q, err_d;
  logic                 ack_d;
  logic [31:0]          dat_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [31:0]          din_d;
  logic                 web_d;
  logic [3:0]           wmask_d;
  logic [MAX_CHIPS-1:0] csb_d;

  logic                 req;
  logic                 csr_sel;
  logic [3:0]           req_chip;
  logic [17:0]          csr_off;
  logic                 pop_hit;
  logic [31:0]          csr_rdata;
  logic [31:0]          rd_slice;
  logic                 err_set;
  logic                 err_clr;

  assign req      = wbs_stb_i && wbs_cyc_i && !wbs_ack_o && (wbs_adr_i[31:24] == 8'h30);
  assign csr_sel  = (wbs_adr_i[23:20] == 4'hF);
  assign req_chip = wbs_adr_i[19:16];
  assign csr_off  = wbs_adr_i[19:2];
  assign err_o    = err_q;

  // Populated-bit lookup for the requested chip; chips beyond MAX_CHIPS count as empty
  always_comb begin
    pop_hit = 1'b0;
    for (int unsigned k = 0; k < MAX_CHIPS; k++) begin
      if (32'(req_chip) == k) pop_hit = pop_q[k];
    end
  end

  // Select the latched chip's dout slice for read capture
  always_comb begin
    rd_slice = '0;
    for (int unsigned k = 0; k < MAX_CHIPS; k++) begin
      if (32'(chip_q) == k) rd_slice = sram_dout_i[32*k +: 32];
    end
  end

  // CSR read mux
  always_comb begin
    csr_rdata = '0;
    case (csr_off)
      18'd0:   csr_rdata = 32'(pop_q);
      18'd1:   csr_rdata = {31'b0, err_q};
      default: csr_rdata = '0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    chip_d  = chip_q;
    cnt_d   = cnt_q;
    pop_d   = pop_q;
    ack_d   = 1'b0;
    dat_d   = wbs_dat_o;
    addr_d  = addr0;
    din_d   = din0;
    wmask_d = wmask0;
    web_d   = 1'b1;
    csb_d   = '1;
    err_set = 1'b0;
    err_clr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (csr_sel) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            if (wbs_we_i) begin
              if (csr_off == 18'd0) pop_d = wbs_dat_i[MAX_CHIPS-1:0];
              if ((csr_off == 18'd1) && wbs_dat_i[0]) err_clr = 1'b1;
            end else begin
              dat_d = csr_rdata;
            end
          end else if (!pop_hit) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            err_set = 1'b1;
            if (!wbs_we_i) dat_d = ERR_WORD;
          end else if (wbs_we_i && (wbs_sel_i == 4'h0)) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
          end else begin
            state_d = S_CMD;
            chip_d  = req_chip;
            addr_d  = wbs_adr_i[ADDR_W+1:2];
            din_d   = wbs_dat_i;
            wmask_d = wbs_we_i ? wbs_sel_i : 4'hF;
            web_d   = ~wbs_we_i;
            for (int unsigned k = 0; k < MAX_CHIPS; k++) begin
              if (32'(req_chip) == k) csb_d[k] = 1'b0;
            end
          end
        end
      end
      S_CMD: begin
        if (!web0) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          dat_d   = rd_slice;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      chip_q    <= '0;
      cnt_q     <= '0;
      pop_q     <= POP_MASK;
      err_q     <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      addr0     <= '0;
      din0      <= '0;
      web0      <= 1'b1;
      wmask0    <= '0;
      csb0      <= '1;
    end else begin
      state_q   <= state_d;
      chip_q    <= chip_d;
      cnt_q     <= cnt_d;
      pop_q     <= pop_d;
      err_q     <= err_d;
      wbs_ack_o <= ack_d;
      wbs_dat_o <= dat_d;
      addr0     <= addr_d;
      din0      <= din_d;
      web0      <= web_d;
      wmask0    <= wmask_d;
      csb0      <= csb_d;
    end
  end

endmodule

// File: tb/tb_openram_wb_port.sv
// Self-checking bench for openram_wb_port with a behavioural 2-cycle SRAM model.
module tb_openram_wb_port;
  localparam int ADDR_W    = 10;
  localparam int MAX_CHIPS = 16;
  localparam int RD_LAT    = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    mem_clear = 1'b1;
  logic                    wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]              wbs_sel_i = 4'h0;
  logic [31:0]             wbs_adr_i = '0, wbs_dat_i = '0;
  logic                    wbs_ack_o;
  logic [31:0]             wbs_dat_o;
  logic [ADDR_W-1:0]       addr0;
  logic [31:0]             din0;
  logic                    web0;
  logic [3:0]              wmask0;
  logic [MAX_CHIPS-1:0]    csb0;
  logic [32*MAX_CHIPS-1:0] sram_dout;
  logic                    err_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  openram_wb_port #(.ADDR_W(ADDR_W), .MAX_CHIPS(MAX_CHIPS), .RD_LAT(RD_LAT),
                    .POP_MASK(16'h0F1F)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .addr0(addr0), .din0(din0), .web0(web0), .wmask0(wmask0), .csb0(csb0),
    .sram_dout_i(sram_dout), .err_o(err_o)
  );

  function automatic logic [31:0] init_word(int c, int a);
    return 32'hA5000000 | (32'(c) << 16) | 32'(a);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    return w;
  endfunction

  // SRAM macro model: dout valid two edges after the command edge
  logic [31:0] sram_mem [0:15][0:1023];
  logic        p1_v, p2_v;
  logic [3:0]  p1_c, p2_c;
  logic [31:0] p1_d, p2_d;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int c = 0; c < 16; c++)
        for (int a = 0; a < 1024; a++) sram_mem[c][a] <= init_word(c, a);
      p1_v <= 1'b0;
      p2_v <= 1'b0;
    end else begin
      p2_v <= p1_v; p2_c <= p1_c; p2_d <= p1_d;
      p1_v <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (!csb0[k]) begin
          if (!web0) sram_mem[k][addr0] <= merge(sram_mem[k][addr0], din0, wmask0);
          else begin
            p1_v <= 1'b1; p1_c <= 4'(k); p1_d <= sram_mem[k][addr0];
          end
        end
      end
    end
  end

  always_comb begin
    sram_dout = '0;
    for (int k = 0; k < MAX_CHIPS; k++)
      sram_dout[32*k +: 32] = (p2_v && (int'(p2_c) == k)) ? p2_d : (32'hDEAD0000 | 32'(k));
  end

  // Reference contents and read scoreboard
  logic [31:0] ref_mem [int];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] ref_read(int c, int a);
    if (ref_mem.exists(c * 1024 + a)) return ref_mem[c * 1024 + a];
    return init_word(c, a);
  endfunction

  task automatic ref_write(int c, int a, logic [31:0] d, logic [3:0] m);
    ref_mem[c * 1024 + a] = merge(ref_read(c, a), d, m);
  endtask

  // Transfer driver: records the first-cycle bus snapshot and ack latency
  logic [MAX_CHIPS-1:0] snap_csb;
  logic                 snap_web;
  logic [ADDR_W-1:0]    snap_addr;
  logic [31:0]          snap_din;
  logic [3:0]           snap_wmask;
  int                   csb_low_cnt;
  int                   csb_multi;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    lat = -1; csb_low_cnt = 0; csb_multi = 0; rd = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      step();
      if (c == 1) begin
        snap_csb = csb0; snap_web = web0; snap_addr = addr0;
        snap_din = din0; snap_wmask = wmask0;
      end
      if (csb0 != '1) begin
        csb_low_cnt++;
        if ($countones(~csb0) != 1) csb_multi = 1;
      end
      if (wbs_ack_o) begin lat = c; rd = wbs_dat_o; end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat;
    rst = 1'b1; mem_clear = 1'b1;
    repeat (3) step();
    rst = 1'b0; mem_clear = 1'b0;
    n_checks++; if ({wbs_ack_o, wbs_dat_o} !== 33'h0) begin n_fail++; $display("FAIL rst_wb: ack=%b dat=%h want 0/0", wbs_ack_o, wbs_dat_o); end
    n_checks++; if ({csb0, web0, wmask0, addr0, din0, err_o} !== {16'hFFFF, 1'b1, 4'h0, 10'h0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL rst_bus: csb=%h web=%b wm=%h a=%h d=%h err=%b", csb0, web0, wmask0, addr0, din0, err_o); end
    wb_xfer(1'b0, 32'h30F0_0000, 32'h0, 4'hF, rd, lat);
    n_checks++; if (lat !== 1 || rd !== 32'h0000_0F1F) begin n_fail++; $display("FAIL rst_pop: lat=%0d pop=%h want 1/00000F1F", lat, rd); end
  endtask

  task automatic test_write();
    logic [31:0] rd; int lat;
    wb_xfer(1'b1, 32'h3001_0008, 32'hCAFEF00D, 4'hF, rd, lat);
    ref_write(1, 2, 32'hCAFEF00D, 4'hF);
    n_checks++; if ({snap_csb, snap_web, snap_addr, snap_din, snap_wmask} !== {16'hFFFD, 1'b0, 10'd2, 32'hCAFEF00D, 4'hF}) begin
      n_fail++; $display("FAIL wr_cmd: csb=%h web=%b a=%h d=%h wm=%h", snap_csb, snap_web, snap_addr, snap_din, snap_wmask); end
    n_checks++; if (lat !== 2 || csb_low_cnt !== 1) begin n_fail++; $display("FAIL wr_ack: lat=%0d csb_cycles=%0d want 2/1", lat, csb_low_cnt); end
  endtask

  task automatic test_read();
    logic [31:0] rd; int lat;
    logic [31:0] exp_v;
    exp_q.push_back(ref_read(1, 2));
    wb_xfer(1'b0, 32'h3001_0008, 32'h0, 4'hF, rd, lat);
    exp_v = exp_q.pop_front();
    n_checks++; if (snap_csb !== 16'hFFFD || snap_web !== 1'b1 || snap_wmask !== 4'hF) begin
      n_fail++; $display("FAIL rd_cmd: csb=%h web=%b wm=%h want FFFD/1/F", snap_csb, snap_web, snap_wmask); end
    n_checks++; if (lat !== 2 + RD_LAT || rd !== exp_v) begin n_fail++; $display("FAIL rd_data: lat=%0d dat=%h want %0d/%h", lat, rd, 2 + RD_LAT, exp_v); end
    exp_q.push_back(ref_read(8, 1023));
    wb_xfer(1'b0, 32'h3008_0FFC, 32'h0, 4'hF, rd, lat);
    exp_v = exp_q.pop_front();
    n_checks++; if (snap_csb !== 16'hFEFF || snap_addr !== 10'h3FF || rd !== exp_v || csb_multi !== 0) begin
      n_fail++; $display("FAIL rd_top: csb=%h a=%h dat=%h want FEFF/3FF/%h", snap_csb, snap_addr, rd, exp_v); end
  endtask

  task automatic test_wmask();
    logic [31:0] rd; int lat;
    logic [31:0] exp_v;
    wb_xfer(1'b1, 32'h3000_0014, 32'h11223344, 4'b0101, rd, lat);
    ref_write(0, 5, 32'h11223344, 4'b0101);
    n_checks++; if (snap_wmask !== 4'b0101 || snap_csb !== 16'hFFFE || lat !== 2) begin
      n_fail++; $display("FAIL wmask: wm=%h csb=%h lat=%0d want 5/FFFE/2", snap_wmask, snap_csb, lat); end
    exp_q.push_back(ref_read(0, 5));
    wb_xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, rd, lat);
    exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v) begin n_fail++; $display("FAIL wmask_rd: dat=%h want %h", rd, exp_v); end
    wb_xfer(1'b1, 32'h3000_0014, 32'hFFFFFFFF, 4'h0, rd, lat);
    n_checks++; if (lat !== 1 || csb_low_cnt !== 0) begin n_fail++; $display("FAIL sel0: lat=%0d csb_cycles=%0d want 1/0", lat, csb_low_cnt); end
  endtask

  task automatic test_unpop();
    logic [31:0] rd; int lat;
    wb_xfer(1'b0, 32'h3005_0000, 32'h0, 4'hF, rd, lat);
    n_checks++; if (lat !== 1 || rd !== 32'hBADC0DE0 || csb_low_cnt !== 0 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL unpop: lat=%0d dat=%h csb_cycles=%0d err=%b", lat, rd, csb_low_cnt, err_o); end
    wb_xfer(1'b0, 32'h30F0_0004, 32'h0, 4'hF, rd, lat);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL status_rd: got %h want 1", rd); end
    wb_xfer(1'b1, 32'h30F0_0004, 32'h1, 4'h0, rd, lat);
    n_checks++; if (err_o !== 1'b0 || lat !== 1) begin n_fail++; $display("FAIL err_clr: err=%b lat=%0d want 0/1", err_o, lat); end
  endtask

  task automatic test_csr();
    logic [31:0] rd; int lat;
    logic [31:0] exp_v;
    wb_xfer(1'b1, 32'h30F0_0000, 32'hFFFFFFFF, 4'h0, rd, lat);
    wb_xfer(1'b0, 32'h30F0_0000, 32'h0, 4'hF, rd, lat);
    n_checks++; if (rd !== 32'h0000FFFF) begin n_fail++; $display("FAIL pop_wide: got %h want 0000FFFF", rd); end
    exp_q.push_back(ref_read(5, 3));
    wb_xfer(1'b0, 32'h3005_000C, 32'h0, 4'hF, rd, lat);
    exp_v = exp_q.pop_front();
    n_checks++; if (rd !== exp_v || lat !== 2 + RD_LAT || err_o !== 1'b0) begin
      n_fail++; $display("FAIL chip5_pop: dat=%h lat=%0d err=%b want %h", rd, lat, err_o, exp_v); end
    wb_xfer(1'b1, 32'h30F0_0008, 32'h12345678, 4'hF, rd, lat);
    wb_xfer(1'b0, 32'h30F0_0008, 32'h0, 4'hF, rd, lat);
    n_checks++; if (rd !== 32'h0 || lat !== 1) begin n_fail++; $display("FAIL csr_other: got %h lat=%0d want 0/1", rd, lat); end
    wb_xfer(1'b1, 32'h30F0_0000, 32'h00000F1F, 4'hF, rd, lat);
    wb_xfer(1'b0, 32'h2001_0008, 32'h0, 4'hF, rd, lat);
    n_checks++; if (lat !== -1 || csb_low_cnt !== 0) begin n_fail++; $display("FAIL nodecode: lat=%0d csb_cycles=%0d want -1/0", lat, csb_low_cnt); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat;
    logic [31:0] exp_v;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3000_0014; wbs_sel_i = 4'hF;
    step();
    step();
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    step();
    n_checks++; if (wbs_ack_o !== 1'b0 || csb0 !== 16'hFFFF) begin n_fail++; $display("FAIL abort_idle: ack=%b csb=%h want 0/FFFF", wbs_ack_o, csb0); end
    exp_q.push_back(ref_read(1, 2));
    wb_xfer(1'b0, 32'h3001_0008, 32'h0, 4'hF, rd, lat);
    exp_v = exp_q.pop_front();
    n_checks++; if (lat !== 2 + RD_LAT || rd !== exp_v) begin n_fail++; $display("FAIL abort_next: lat=%0d dat=%h want %0d/%h", lat, rd, 2 + RD_LAT, exp_v); end
  endtask

  task automatic test_back_to_back();
    int a_seen;
    int extra_ack;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3002_0004; wbs_sel_i = 4'hF;
    a_seen = 0;
    for (int c = 0; c < 20 && a_seen == 0; c++) begin
      step();
      if (wbs_ack_o) a_seen = 1;
    end
    n_checks++; if (a_seen !== 1 || wbs_dat_o !== init_word(2, 1)) begin n_fail++; $display("FAIL b2b_first: ack=%0d dat=%h want 1/%h", a_seen, wbs_dat_o, init_word(2, 1)); end
    step();
    n_checks++; if (wbs_ack_o !== 1'b0 || csb0 !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_idle: ack=%b csb=%h want 0/FFFF", wbs_ack_o, csb0); end
    step();
    n_checks++; if (csb0 !== 16'hFFFB) begin n_fail++; $display("FAIL b2b_second: csb=%h want FFFB", csb0); end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    extra_ack = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (wbs_ack_o) extra_ack++;
    end
    n_checks++; if (extra_ack !== 0) begin n_fail++; $display("FAIL b2b_abort: acks=%0d want 0", extra_ack); end
  endtask

  task automatic test_rst_wait();
    logic [31:0] rd; int lat;
    wb_xfer(1'b0, 32'h3006_0000, 32'h0, 4'hF, rd, lat);
    wb_xfer(1'b1, 32'h30F0_0000, 32'h3, 4'hF, rd, lat);
    n_checks++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL pre_rst_err: err=%b want 1", err_o); end
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3001_0008; wbs_sel_i = 4'hF;
    step();
    step();
    rst = 1'b1;
    step();
    n_checks++; if ({wbs_ack_o, csb0, web0, err_o, wbs_dat_o} !== {1'b0, 16'hFFFF, 1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rst_wait: ack=%b csb=%h web=%b err=%b dat=%h", wbs_ack_o, csb0, web0, err_o, wbs_dat_o); end
    rst = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    step();
    wb_xfer(1'b0, 32'h30F0_0000, 32'h0, 4'hF, rd, lat);
    n_checks++; if (rd !== 32'h0000_0F1F || lat !== 1) begin n_fail++; $display("FAIL rst_pop: pop=%h lat=%0d want 00000F1F/1", rd, lat); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wmask();
    test_unpop();
    test_csr();
    test_abort();
    test_back_to_back();
    test_rst_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
